// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential shift divider.
// The signed datapath helpers are only referenced when DIV_SIGNED_EN is defined.
package div_pkg;

    // State encodings, kept explicit so debug views and checkers can decode them.
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        RUN  = ST_RUN_ENC,
        DONE = ST_DONE_ENC
    } div_state_t;

    // Widest operand the magnitude helper handles; callers sign-extend into it.
    localparam int DIV_MAX_W = 64;

    // Magnitude of a sign-extended operand. When is_signed is 0 the value is
    // returned untouched. The most-negative value maps to its unsigned
    // magnitude in the low bits, which is what the iteration needs.
    function automatic logic [DIV_MAX_W-1:0] abs_val(input logic [DIV_MAX_W-1:0] value,
                                                     input logic                 is_signed);
        logic [DIV_MAX_W-1:0] mag;
        if (is_signed && value[DIV_MAX_W-1]) begin
            mag = (~value) + DIV_MAX_W'(1);
        end else begin
            mag = value;
        end
        return mag;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D,
// and insert the resulting quotient bit at the bottom of Q.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] r_ext_s;
    logic [WIDTH:0] trial_s;
    logic           qbit_s;

    // Trial subtract at WIDTH+1 bits; the bit shifted out of R is kept so
    // divisors with the top bit set still divide correctly.
    always_comb begin
        r_ext_s = {r_i, q_i[WIDTH-1]};
        trial_s = r_ext_s - {1'b0, d_i};
        if (trial_s[WIDTH] == 1'b0) begin
            r_o    = trial_s[WIDTH-1:0];
            qbit_s = 1'b1;
        end else begin
            r_o    = r_ext_s[WIDTH-1:0];
            qbit_s = 1'b0;
        end
        q_o = {q_i[WIDTH-2:0], qbit_s};
    end

endmodule

// File: rtl/seq_shift_divider.sv
// Iterative restoring divider with start/ready handshake.
// Signed operation (sign-magnitude pre/post processing) is built only when
// DIV_SIGNED_EN is defined; otherwise is_signed is ignored.
module seq_shift_divider
    import div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0] step_r_s, step_q_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

`ifdef DIV_SIGNED_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             a_neg_s, b_neg_s;
    logic [DIV_MAX_W-1:0] a_abs_s, b_abs_s;
    logic             unused_abs_hi_s;

    assign a_neg_s   = is_signed & dividend[WIDTH-1];
    assign b_neg_s   = is_signed & divisor[WIDTH-1];
    assign a_abs_s   = abs_val(DIV_MAX_W'($signed(dividend)), is_signed);
    assign b_abs_s   = abs_val(DIV_MAX_W'($signed(divisor)), is_signed);
    assign a_mag_s   = a_abs_s[WIDTH-1:0];
    assign b_mag_s   = b_abs_s[WIDTH-1:0];
    assign unused_abs_hi_s = ^{a_abs_s, b_abs_s};
    assign quo_fix_s = neg_quo_q ? ((~q_q) + WIDTH'(1)) : q_q;
    assign rem_fix_s = neg_rem_q ? ((~r_q) + WIDTH'(1)) : r_q;
`else
    logic unused_is_signed_s;

    assign unused_is_signed_s = is_signed;
    assign a_mag_s   = dividend;
    assign b_mag_s   = divisor;
    assign quo_fix_s = q_q;
    assign rem_fix_s = r_q;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r_s),
        .q_o (step_q_s)
    );

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            r_q       <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            d_q       <= {WIDTH{1'b0}};
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            quo_q     <= {WIDTH{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            exc_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            exc_q     <= exc_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    // Next-state and datapath control; results only move in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        dz_d      = dz_q;
        ready_d   = 1'b0;
        quo_d     = quo_q;
        rem_d     = rem_q;
        exc_d     = exc_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                // A start coinciding with the ready pulse is deliberately dropped.
                if (start && !ready_q) begin
                    cnt_d = {CNT_W{1'b0}};
                    r_d   = {WIDTH{1'b0}};
                    if (divisor != {WIDTH{1'b0}}) begin
                        q_d       = a_mag_s;
                        d_d       = b_mag_s;
                        dz_d      = 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = a_neg_s ^ b_neg_s;
                        neg_rem_d = a_neg_s;
`endif
                        state_d   = RUN;
                    end else begin
                        q_d       = {WIDTH{1'b0}};
                        d_d       = {WIDTH{1'b0}};
                        dz_d      = 1'b1;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
`endif
                        state_d   = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = step_r_s;
                q_d   = step_q_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                dz_d    = 1'b0;
                state_d = IDLE;
                if (dz_q) begin
                    quo_d = {WIDTH{1'b0}};
                    rem_d = {WIDTH{1'b0}};
                    exc_d = 1'b1;
                end else begin
                    quo_d = quo_fix_s;
                    rem_d = rem_fix_s;
                    exc_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign busy      = busy_q;
    assign ready     = ready_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign exception = exc_q;

endmodule
